regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the RV32IC pipeline, successor to the single-read-port regfile. It provides `NRD` independent synchronous read ports and one write port. A write-first bypass applies to every read port. Register `x0` is hardwired to zero (configurable), each read port has its own enable so the decode stage can hold operands during stalls, and reset asynchronously clears the whole array. It sits between IF/ID decode (read side) and writeback (write side).

---
 rtl/regfile_mp.sv | 83 ++++++++
 tb/tb_regfile_mp.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with write-first bypass
// Flop-based array so the asynchronous reset can clear every entry at once.
module regfile_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_SIZE   = 32,
  parameter int NRD        = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [ADDR_WIDTH-1:0]      write_addr,
  input  logic [DATA_WIDTH-1:0]      din,
  input  logic [NRD-1:0]             re,
  input  logic [NRD*ADDR_WIDTH-1:0]  read_addr,
  output logic [NRD*DATA_WIDTH-1:0]  dout
);

  // One extra bit so RAM_SIZE == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0] RAM_LIMIT = (ADDR_WIDTH+1)'(RAM_SIZE);

  logic [DATA_WIDTH-1:0] ram [RAM_SIZE];
  logic                  wr_in_range;
  logic                  wr_is_zero;
  logic                  wv;

  assign wr_in_range = ({1'b0, write_addr} < RAM_LIMIT);
  assign wr_is_zero  = (ZERO_REG != 0) && (write_addr == '0);
  assign wv          = we && wr_in_range && !wr_is_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAM_SIZE; i++) begin
        ram[i] <= '0;
      end
    end else if (wv) begin
      for (int i = 0; i < RAM_SIZE; i++) begin
        if (write_addr == ADDR_WIDTH'(i)) begin
          ram[i] <= din;
        end
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd_next;
    logic [DATA_WIDTH-1:0] rd_q;

    assign ra = read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

    // Later assignments win, so the priority order reads bottom-up.
    always_comb begin
      rd_next = '0;
      for (int i = 0; i < RAM_SIZE; i++) begin
        if (ra == ADDR_WIDTH'(i)) begin
          rd_next = ram[i];
        end
      end
      if (wv && (ra == write_addr)) begin
        rd_next = din;
      end
      if ({1'b0, ra} >= RAM_LIMIT) begin
        rd_next = '0;
      end
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_next = '0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_q <= '0;
      end else if (re[p]) begin
        rd_q <= rd_next;
      end
    end

    assign dout[p*DATA_WIDTH +: DATA_WIDTH] = rd_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed vector bench for regfile_mp
// Three instances share stimulus: default, ZERO_REG=0, and RAM_SIZE=16.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  write_addr = '0;
  logic [31:0] din = '0;
  logic [1:0]  re = '0;
  logic [9:0]  read_addr = '0;
  logic [63:0] dout_m;
  logic [63:0] dout_z;
  logic [63:0] dout_o;

  int checks = 0;
  int errors = 0;

  regfile_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .RAM_SIZE(32), .NRD(2), .ZERO_REG(1)) dut_m (
    .clk(clk), .rst(rst), .we(we), .write_addr(write_addr), .din(din),
    .re(re), .read_addr(read_addr), .dout(dout_m)
  );

  regfile_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .RAM_SIZE(32), .NRD(2), .ZERO_REG(0)) dut_z (
    .clk(clk), .rst(rst), .we(we), .write_addr(write_addr), .din(din),
    .re(re), .read_addr(read_addr), .dout(dout_z)
  );

  regfile_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .RAM_SIZE(16), .NRD(2), .ZERO_REG(1)) dut_o (
    .clk(clk), .rst(rst), .we(we), .write_addr(write_addr), .din(din),
    .re(re), .read_addr(read_addr), .dout(dout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  re;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] m0, m1, z0, z1, o0, o1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic w, int wa, logic [31:0] wd, logic [1:0] r, int ra0, int ra1,
                              logic [31:0] m0, logic [31:0] m1, logic [31:0] z0, logic [31:0] z1,
                              logic [31:0] o0, logic [31:0] o1);
    vec_t v;
    v.we = w; v.wa = 5'(wa); v.wd = wd; v.re = r; v.ra0 = 5'(ra0); v.ra1 = 5'(ra1);
    v.m0 = m0; v.m1 = m1; v.z0 = z0; v.z1 = z1; v.o0 = o0; v.o1 = o1;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc(logic w, logic [4:0] wa, logic [31:0] wd, logic [1:0] r,
                     logic [4:0] ra0, logic [4:0] ra1);
    we = w; write_addr = wa; din = wd; re = r; read_addr = {ra1, ra0};
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Shared-stimulus vectors applied right after reset; all registers start at 0.
    tbl.push_back(mk(1, 1,  32'h11111111, 2'b00, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2,  32'h22222222, 2'b00, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,  32'h0,        2'b11, 1, 2,
                     32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222));
    tbl.push_back(mk(1, 3,  32'hAAAA0000, 2'b00, 1, 2,
                     32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222));
    tbl.push_back(mk(1, 3,  32'h0000BBBB, 2'b11, 3, 3,
                     32'h0000BBBB, 32'h0000BBBB, 32'h0000BBBB, 32'h0000BBBB, 32'h0000BBBB, 32'h0000BBBB));
    tbl.push_back(mk(0, 0,  32'h0,        2'b01, 3, 1,
                     32'h0000BBBB, 32'h0000BBBB, 32'h0000BBBB, 32'h0000BBBB, 32'h0000BBBB, 32'h0000BBBB));
    tbl.push_back(mk(1, 0,  32'hFFFFFFFF, 2'b11, 0, 0,
                     32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0));
    tbl.push_back(mk(0, 0,  32'h0,        2'b11, 0, 1,
                     32'h0, 32'h11111111, 32'hFFFFFFFF, 32'h11111111, 32'h0, 32'h11111111));
    tbl.push_back(mk(1, 4,  32'h12345678, 2'b00, 0, 1,
                     32'h0, 32'h11111111, 32'hFFFFFFFF, 32'h11111111, 32'h0, 32'h11111111));
    tbl.push_back(mk(0, 0,  32'h0,        2'b01, 4, 1,
                     32'h12345678, 32'h11111111, 32'h12345678, 32'h11111111, 32'h12345678, 32'h11111111));
    tbl.push_back(mk(1, 4,  32'h87654321, 2'b00, 4, 1,
                     32'h12345678, 32'h11111111, 32'h12345678, 32'h11111111, 32'h12345678, 32'h11111111));
    tbl.push_back(mk(0, 0,  32'h0,        2'b01, 4, 1,
                     32'h87654321, 32'h11111111, 32'h87654321, 32'h11111111, 32'h87654321, 32'h11111111));
    tbl.push_back(mk(1, 31, 32'h5A5A5A5A, 2'b10, 4, 31,
                     32'h87654321, 32'h5A5A5A5A, 32'h87654321, 32'h5A5A5A5A, 32'h87654321, 32'h0));
    tbl.push_back(mk(1, 2,  32'hCAFE0002, 2'b11, 2, 31,
                     32'hCAFE0002, 32'h5A5A5A5A, 32'hCAFE0002, 32'h5A5A5A5A, 32'hCAFE0002, 32'h0));
    tbl.push_back(mk(0, 0,  32'h0,        2'b11, 31, 2,
                     32'h5A5A5A5A, 32'hCAFE0002, 32'h5A5A5A5A, 32'hCAFE0002, 32'h0, 32'hCAFE0002));

    // Power-on reset: outputs clear without any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("por_m", dout_m, 64'h0);
    chk("por_z", dout_z, 64'h0);
    chk("por_o", dout_o, 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra0, tbl[i].ra1);
      chk($sformatf("v%0d_m", i), dout_m, {tbl[i].m1, tbl[i].m0});
      chk($sformatf("v%0d_z", i), dout_z, {tbl[i].z1, tbl[i].z0});
      chk($sformatf("v%0d_o", i), dout_o, {tbl[i].o1, tbl[i].o0});
    end

    // Asynchronous reset mid-cycle, with a write pending across the reset edge.
    cyc(1, 5, 32'hDEADBEEF, 2'b11, 5, 31);
    chk("x5_bypass_m", dout_m, {32'h5A5A5A5A, 32'hDEADBEEF});
    we = 1'b1; write_addr = 5'd5; din = 32'h12345678; re = 2'b11;
    #2 rst = 1'b1;
    #1;
    chk("arst_m", dout_m, 64'h0);
    chk("arst_z", dout_z, 64'h0);
    chk("arst_o", dout_o, 64'h0);
    @(posedge clk);
    #1;
    chk("arst_hold_m", dout_m, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 32'h0, 2'b11, 5, 31);
    chk("x5_after_rst_m", dout_m, 64'h0);
    chk("x5_after_rst_z", dout_z, 64'h0);
    chk("x5_after_rst_o", dout_o, 64'h0);

    // Out-of-range write on the 16-entry instance must not alias onto 0..15.
    for (int i = 1; i < 16; i++) begin
      cyc(1, 5'(i), 32'(i) * 32'h01010101, 2'b00, 0, 0);
    end
    cyc(1, 20, 32'hCAFEF00D, 2'b11, 20, 20);
    chk("oor_bypass_o", dout_o, 64'h0);
    chk("oor_bypass_m", dout_m, {32'hCAFEF00D, 32'hCAFEF00D});
    for (int i = 0; i < 16; i++) begin
      logic [31:0] exp_lo;
      logic [31:0] exp_hi;
      cyc(0, 0, 32'h0, 2'b11, 5'(i), 5'(i + 16));
      exp_lo = (i == 0) ? 32'h0 : 32'(i) * 32'h01010101;
      exp_hi = (i + 16 == 20) ? 32'hCAFEF00D : 32'h0;
      chk($sformatf("oor_scan%0d_o", i), dout_o, {32'h0, exp_lo});
      chk($sformatf("oor_scan%0d_m", i), dout_m, {exp_hi, exp_lo});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
